subborrow_serial: RTL
=====================

SUBBORROW_SERIAL -- requirements
Module: subborrow_serial

Interface
REQ-001 The block SHALL have parameter W, default 3, giving the difference width in bits; W+1 is the minuend width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 The block SHALL have port S, input, W+1 bits: minuend, i.e. the packed {carry, sum} word of a W-bit adder.
REQ-006 The block SHALL have port B, input, W bits: subtrahend, i.e. the known addend.
REQ-007 The block SHALL have port A, output, W bits: recovered addend, A = (S - B) mod 2^W.
REQ-008 The block SHALL have port err, output, 1 bit: set when S - B is outside the range [0, 2^W-1].
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle completion strobe.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch S and zero-extended B into shift registers, clear the bit counter and borrow, and go to SHIFT.
REQ-013 In SHIFT, each cycle SHALL process one bit, LSB first:
  - d = s0 xor b0 xor bw
  - bw' = (!s0 & b0) | (!s0 & bw) | (b0 & bw)
  - both operand registers shift right
  - d shifts into the MSB of a (W+1)-bit result register.
REQ-014 SHIFT SHALL last exactly W+1 cycles, counted by a counter of width clog2(W+2), then go to DONE.
REQ-015 On entering DONE, the block SHALL load A = result[W-1:0] and err = final borrow OR result[W].
REQ-016 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-017 Latency: done SHALL rise on the clock edge W+2 cycles after the edge that sampled start; this is 5 cycles for W=3.
REQ-018 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored in SHIFT and DONE: no restart, and no change to the latched operands.
REQ-020 Changes on S or B after start is sampled SHALL NOT affect the running operation.
REQ-021 A and err SHALL hold their values from DONE until the next DONE.
REQ-022 If start=1 in the cycle immediately after DONE, the block SHALL accept it; back-to-back throughput is one result per W+3 cycles.
REQ-023 The block SHALL have no combinational path from any input to any output; all outputs SHALL be registered.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force state=IDLE, A=0, err=0, busy=0, done=0, and clear the counter, borrow and shift registers.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-026 After rst_n rises, the block SHALL accept start on the first clock edge.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, SHIFT, DONE) and the default width constant (3).
REQ-028 A one-bit full-subtractor sub-module fullsub1 SHALL compute d and bw' combinationally, with ports s, b, bin, d and bout.
REQ-029 The FSM, counter and shift registers SHALL reside in subborrow_serial.

Verification (W=3)
REQ-030 After reset, pulse start with S=8, B=2 -> done at start+5 cycles with A=6, err=0.
REQ-031 Pulse start with S=7, B=1, then S=0, B=0 back-to-back -> A=6, err=0; then A=0, err=0.
REQ-032 Pulse start with S=1, B=2 -> A=7, err=1 (negative result).
REQ-033 Pulse start with S=15, B=0 -> A=7, err=1 (result overflows W bits).
REQ-034 Pulse start with S=8, B=2, then at cycle +2 pulse start with S=3, B=3 and change S -> result A=6 only, one done pulse, busy stays high throughout.
REQ-035 Pulse start, assert rst_n=0 at cycle +3, release, then start with S=5, B=4 -> outputs 0 immediately on reset with no done; then A=1, err=0.

Source files
------------

// File: rtl/subborrow_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : subborrow_serial_pkg
//  Purpose  : Shared definitions for the bit-serial borrow subtractor:
//             FSM state encoding and the default difference width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package subborrow_serial_pkg;

  // Default difference width; the minuend is one bit wider.
  localparam int DEFAULT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/subborrow_serial_fullsub1.sv
`default_nettype none
// ============================================================================
//  Module   : fullsub1
//  Purpose  : One-bit full subtractor computing s - b - bin.
//  Ports    : s    - minuend bit
//             b    - subtrahend bit
//             bin  - incoming borrow
//             d    - difference bit
//             bout - outgoing borrow
//  Revision : 1.0 - initial release
// ============================================================================
module fullsub1 (
  input  logic s,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = s ^ b ^ bin;
  // A borrow is needed whenever b + bin exceeds s.
  assign bout = (~s & b) | (~s & bin) | (b & bin);

endmodule
`default_nettype wire

// File: rtl/subborrow_serial.sv
`default_nettype none
// ============================================================================
//  Module   : subborrow_serial
//  Purpose  : Bit-serial recovery of an adder operand: A = (S - B) mod 2^W,
//             processed LSB first over W+1 cycles, with an error flag when
//             the true difference does not fit in [0, 2^W-1].
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             start - request pulse, sampled only while idle
//             S     - minuend, W+1 bits ({carry, sum} of a W-bit adder)
//             B     - subtrahend, W bits
//             A     - recovered addend (registered)
//             err   - difference out of range (registered)
//             busy  - operation in progress (registered)
//             done  - single-cycle completion strobe (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module subborrow_serial
  import subborrow_serial_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W:0]   S,
  input  logic [W-1:0] B,
  output logic [W-1:0] A,
  output logic         err,
  output logic         busy,
  output logic         done
);

  localparam int            CW   = $clog2(W + 2);
  localparam logic [CW-1:0] LAST = CW'(W);

  state_t        state_q;
  logic [W:0]    s_q;
  logic [W:0]    b_q;
  logic [W:0]    res_q;
  logic [CW-1:0] cnt_q;
  logic          bw_q;
  logic [W-1:0]  a_q;
  logic          err_q;
  logic          busy_q;
  logic          done_q;

  logic          d_d;
  logic          bw_d;

  fullsub1 u_fullsub1 (
    .s    (s_q[0]),
    .b    (b_q[0]),
    .bin  (bw_q),
    .d    (d_d),
    .bout (bw_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
      a_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            s_q     <= S;
            b_q     <= {1'b0, B};
            res_q   <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          s_q   <= {1'b0, s_q[W:1]};
          b_q   <= {1'b0, b_q[W:1]};
          // Difference bits enter at the top so that after W+1 shifts the
          // LSB of the result sits at bit 0.
          res_q <= {d_d, res_q[W:1]};
          bw_q  <= bw_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // A final borrow means S < B; a set top bit means S - B >= 2^W.
          a_q     <= res_q[W-1:0];
          err_q   <= bw_q | res_q[W];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign A    = a_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire
